// File: rtl/img_pkg.sv
// Shared pixel and window types for the 3x3 neighbourhood pipeline.
package img_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned LANES = 2;

  typedef logic signed [PIX_W-1:0] sample_t;
  typedef sample_t [LANES-1:0]     pixel_t;
  typedef pixel_t [8:0]            window_t;

  typedef enum logic {
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: combinational read, registered write at the same address.
module line_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/window_generator.sv
// Raster pixel stream to 3x3 windows; only fully populated neighbourhoods are flagged valid.
module window_generator
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic    clk,
  input  logic    reset,
  input  pixel_t  pix_in,
  input  logic    pix_valid,
  output logic    pix_ready,
  output window_t window,
  output logic    win_valid,
  output logic    frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned LB_W  = $bits(pixel_t);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  window_t          win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             accept;
  logic [LB_W-1:0]  lb_old_rd, lb_new_rd;

  // Reset blocks buffer writes so a discarded partial frame cannot disturb state.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(LB_W)) u_lb_old (
    .clk       (clk),
    .we_i      (accept && !reset),
    .addr_i    (col_q),
    .wr_data_i (lb_new_rd),
    .rd_data_o (lb_old_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(LB_W)) u_lb_new (
    .clk       (clk),
    .we_i      (accept && !reset),
    .addr_i    (col_q),
    .wr_data_i (pix_in),
    .rd_data_o (lb_new_rd)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    pix_ready   = (state_q == STREAM);
    frame_done  = (state_q == DONE);
    accept      = pix_valid && pix_ready;

    case (state_q)
      STREAM: begin
        if (accept) begin
          for (int unsigned i = 0; i < 3; i++) begin
            win_d[3*i]   = win_q[3*i+1];
            win_d[3*i+1] = win_q[3*i+2];
          end
          win_d[2]    = pixel_t'(lb_old_rd);
          win_d[5]    = pixel_t'(lb_new_rd);
          win_d[8]    = pix_in;
          win_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
          if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(IMG_H - 1)) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = STREAM;
      end
      default: begin
        state_d = STREAM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STREAM;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign window    = win_q;
  assign win_valid = win_valid_q;

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator on a 4x4 frame with hand-derived expected windows.
module tb_window_generator;
  import img_pkg::*;

  logic    clk = 1'b0;
  logic    reset;
  pixel_t  pix_in;
  logic    pix_valid;
  logic    pix_ready;
  window_t window;
  logic    win_valid;
  logic    frame_done;

  int checks = 0;
  int errors = 0;

  int lit_first [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int lit_last  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  always #5 clk = ~clk;

  window_generator #(.IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .window     (window),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic window_t exp_win(input int base, input bit konst, input int r, input int c);
    window_t w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int v0;
        int v1;
        v0 = konst ? -128 : base + 4 * (r - 2 + i) + (c - 2 + j);
        v1 = konst ? 127 : -v0;
        w[3*i+j][0] = 8'(v0);
        w[3*i+j][1] = 8'(v1);
      end
    end
    return w;
  endfunction

  task automatic run_frame(input int base, input bit konst, input bit bubbles,
                           input int npix, input int exp_stall);
    int      nwin;
    int      stalls;
    window_t held;
    nwin = 0;
    for (int idx = 0; idx < npix; idx++) begin
      int r;
      int c;
      int v0;
      int v1;
      r  = idx / 4;
      c  = idx % 4;
      v0 = konst ? -128 : base + idx;
      v1 = konst ? 127 : -v0;
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        held      = window;
        pix_valid = 1'b0;
        pix_in    = 16'($urandom);
        tick();
        check("gap_win_valid", win_valid, 1'b0);
        check("gap_window_hold", window, held);
      end
      pix_valid = 1'b1;
      pix_in[0] = 8'(v0);
      pix_in[1] = 8'(v1);
      stalls    = 0;
      while (!pix_ready && stalls < 4) begin
        tick();
        stalls++;
        check("stall_frame_done", frame_done, 1'b0);
      end
      if (idx > 0) check("stall_count", stalls, 0);
      else if (exp_stall >= 0) check("first_stall", stalls, exp_stall);
      if (!pix_ready) check("ready_timeout", pix_ready, 1'b1);
      tick();
      check("win_valid", win_valid, (r >= 2) && (c >= 2));
      check("frame_done", frame_done, idx == 15);
      check("pix_ready", pix_ready, idx != 15);
      if (win_valid) begin
        nwin++;
        check("window", window, exp_win(base, konst, r, c));
        if (!konst && r == 2 && c == 2) begin
          for (int k = 0; k < 9; k++) begin
            check("first_lane0", {window[k][0]}, {8'(base + lit_first[k])});
            check("first_lane1", {window[k][1]}, {8'(-(base + lit_first[k]))});
          end
        end
        if (!konst && r == 3 && c == 3) begin
          for (int k = 0; k < 9; k++) begin
            check("last_lane0", {window[k][0]}, {8'(base + lit_last[k])});
          end
        end
      end
    end
    pix_valid = 1'b0;
    if (npix == 16) check("win_count", nwin, 4);
  endtask

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 16'h5A3C;
    repeat (3) begin
      tick();
      check("rst_window", window, '0);
      check("rst_win_valid", win_valid, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
    end
    pix_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check("rst_pix_ready", pix_ready, 1'b1);

    run_frame(0, 1'b0, 1'b0, 16, 0);
    run_frame(100, 1'b0, 1'b0, 16, 1);

    tick();
    check("idle_frame_done", frame_done, 1'b0);
    check("idle_pix_ready", pix_ready, 1'b1);

    run_frame(0, 1'b0, 1'b1, 16, -1);

    // Mid-frame reset after 7 accepts, then a clean frame.
    run_frame(50, 1'b0, 1'b0, 7, 1);
    reset     = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 16'h7F80;
    tick();
    check("midrst_win_valid", win_valid, 1'b0);
    check("midrst_window", window, '0);
    check("midrst_frame_done", frame_done, 1'b0);
    reset     = 1'b0;
    pix_valid = 1'b0;
    run_frame(0, 1'b0, 1'b0, 16, 0);

    run_frame(0, 1'b1, 1'b0, 16, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
- Converts a raster-order stream of signed 8-bit, 2-lane pixels into 3x3 neighbourhood windows.
- Its output window bus is exactly the 9x2 image input consumed by the Smoothening averaging stage.
- It is the producer end of that window interface.
- Two line buffers hold the previous two rows; a 3x3 register array forms the window.
- Only fully populated windows are emitted; there is no border padding.

Parameters:
IMG_W, 64, pixels per line (>= 3)
IMG_H, 64, lines per frame (>= 3)
PIX_W, 8, bits per lane sample (signed)
LANES, 2, independent channels per pixel

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pix_in  in  signed [PIX_W-1:0] x [LANES]  incoming pixel, all lanes
pix_valid  in  1  pix_in valid
pix_ready  out  1  block can accept; beat accepted when pix_valid && pix_ready
window  out  signed [PIX_W-1:0] x [9][LANES]  window[3*i+j][l]: i = row (0 oldest, 2 newest), j = column (0 leftmost)
win_valid  out  1  one-cycle pulse, window holds a new complete neighbourhood
frame_done  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: window all zeros; win_valid = 0; frame_done = 0; pix_ready = 1 from the first cycle after reset deasserts. Column counter col = 0, row counter row = 0, state = STREAM. Line buffer contents are not cleared; they are don't-care because validity is gated by the counters.
- FSM states:
  - STREAM: pix_ready = 1.
  - DONE: exactly one cycle; pix_ready = 0, frame_done = 1; then returns to STREAM with row = col = 0.
- Accepted beat at (row, col) with pixel p:
  - Line buffers: lb_old[col] <= lb_new[col]; lb_new[col] <= p. Reads are combinational, i.e. pre-update values.
  - Window shift: column 0 <= column 1, column 1 <= column 2, column 2 <= {lb_old[col], lb_new[col], p} for rows 0, 1, 2.
  - win_valid <= (row >= 2 && col >= 2).
  - Counters: col increments; at col = IMG_W-1, col wraps to 0 and row increments.
  - Last pixel of the frame (row = IMG_H-1, col = IMG_W-1): next state is DONE.
- Latency: window and win_valid update the cycle after the accepting edge. For the beat at (r, c), window = rows r-2..r, columns c-2..c.
- No accept in a cycle: window holds, win_valid = 0, counters and buffers unchanged.
- Windows per frame: exactly (IMG_W-2)*(IMG_H-2).
- Row wrap: windows never straddle lines. At col 0 and col 1 of every row, win_valid stays 0 even though the shift registers still load.
- Arithmetic: pure data movement; samples pass bit-exact, sign preserved, no width change.
- Back-to-back frames: the first pixel of the next frame is accepted the cycle after DONE. Stale line-buffer data from the previous frame never appears in a window flagged valid.
- Reset mid-frame: takes priority over any accept in the same cycle. Returns to the reset values above; the partial frame is discarded.
- No downstream backpressure: the consumer is always-accepting.

Decomposition:
- Package img_pkg:
  - PIX_W, LANES
  - typedef pixel_t (logic signed [PIX_W-1:0] [LANES])
  - typedef window_t (pixel_t [9])
  - enum state_t {STREAM, DONE}
- Sub-module line_buffer: depth IMG_W, width PIX_W*LANES, combinational read and registered write at the same address. It is instantiated twice (lb_old, lb_new).

Test Plan:
- Reset: hold reset 3 cycles with pix_valid=1 -> window all 0, win_valid=0, frame_done=0 throughout; pix_ready=1 the cycle after release.
- Ramp frame, IMG_W=IMG_H=4, lane0=4r+c, lane1=-(4r+c), continuous valid:
  - First win_valid comes one cycle after accepting value 10. Lane0 window = {0,1,2,4,5,6,8,9,10}; lane1 is the negation.
  - Exactly 4 win_valid pulses, the last with lane0 {5,6,7,9,10,11,13,14,15}.
- Bubbles: same frame with pix_valid dropped on random cycles -> identical 4 windows in order; win_valid only after accepts; window stable during gaps.
- Frame boundary:
  - After the 16th accept: frame_done=1 and pix_ready=0 for exactly one cycle.
  - Second frame with lane0=100+4r+c -> its first window lane0 = {100,101,102,104,105,106,108,109,110}.
- Mid-frame reset: reset after 7 accepts, then a fresh ramp -> no win_valid until the 11th new accept, whose window matches the ramp case.
- Extremes: all pixels lane0=-128, lane1=127 -> every window element is exactly -128 / 127.
